axi_tdd_ng_counter: RTL and testbench
=====================================

// Module: axi_tdd_ng_counter
// PURPOSE
//  TDD frame timing core; sits directly downstream of the TDD sync generator and consumes its sync_out pulse.
//  Arms on enable, waits for a sync, counts the startup delay, then runs tdd_burst_count frames of tdd_frame_length cycles.
//  Publishes state, frame counter and end-of-frame strobe to the channel comparators.
// PARAMETERS
//  REGISTER_WIDTH     32  width of delay, frame length and frame counter
//  BURST_COUNT_WIDTH  32  width of burst count and frame-in-burst counter
// PORTS
//  clk                input   1                   clock
//  resetn             input   1                   reset, synchronous, active-low
//  tdd_enable         input   1                   core enable (level)
//  tdd_sync           input   1                   sync pulse from sync generator (1 cycle)
//  tdd_startup_delay  input   REGISTER_WIDTH      cycles from sync to frame start
//  tdd_frame_length   input   REGISTER_WIDTH      cycles per frame; 0 = 2^REGISTER_WIDTH
//  tdd_burst_count    input   BURST_COUNT_WIDTH   frames per burst; 0 = infinite
//  tdd_cstate         output  2                   state: 0 IDLE, 1 ARMED, 2 WAITING, 3 RUNNING
//  tdd_counter        output  REGISTER_WIDTH      delay counter (WAITING) or frame counter (RUNNING), else 0
//  tdd_endof_frame    output  1                   high on last cycle of each frame
//  tdd_endof_burst    output  1                   high on last cycle of the last frame of a burst
// BEHAVIOUR
//  - Reset: tdd_cstate=IDLE, tdd_counter=0, burst counter=0, shadow regs=0; endof_* low.
//  - tdd_enable low: next edge -> IDLE, counters cleared, from any state; dominates sync in the same cycle.
//  - IDLE & tdd_enable -> ARMED. tdd_sync is sampled only in ARMED; a sync in the IDLE->ARMED cycle is lost.
//  - ARMED & tdd_sync: latch delay, frame length and burst count into shadow regs.
//    If delay != 0 -> WAITING, else -> RUNNING; counter=0 either way.
//  - WAITING: counter increments each cycle; at counter == delay-1 -> RUNNING with counter=0.
//    Total sync-to-RUNNING latency = delay+1 cycles (1 cycle when delay=0).
//  - RUNNING: counter increments; tdd_endof_frame = (state==RUNNING) & (counter == len-1),
//    combinational from registered state. Arithmetic is modulo 2^REGISTER_WIDTH, so len=0 gives 2^W frames.
//  - On end of frame: counter -> 0 and burst counter +1.
//    If burst != 0 and burst counter == burst-1: tdd_endof_burst is high, burst counter -> 0, and the state returns to ARMED.
//  - With burst = 0 the core runs forever; the burst counter holds at 0 and tdd_endof_burst never asserts.
//  - Inputs changing while WAITING/RUNNING have no effect until the next ARMED->sync latch.
//  - tdd_sync in WAITING/RUNNING is ignored (see CONFIGURATION for the alternative).
//  - resetn low mid-frame: all state to reset values at the next edge; no endof_* pulse is emitted.
// CONFIGURATION
//  Macro AXI_TDD_NG_SYNC_RESTART_EN:
//  - defined: tdd_sync in WAITING or RUNNING relatches shadow regs, clears counter and burst counter,
//    and re-enters WAITING (or RUNNING if delay=0). endof_* are suppressed in that cycle.
//  - undefined: sync outside ARMED is ignored.
// STRUCTURE
//  - Package axi_tdd_ng_pkg: typedef enum logic [1:0] state_t {IDLE=0, ARMED=1, WAITING=2, RUNNING=3}.
//  - No sub-module: one FSM always_ff plus counter/shadow always_ff; the endof_* comparators are combinational.
// TESTING
//  1. enable=1, delay=3, len=5, burst=2, sync at t0 -> WAITING t0+1..t0+3, RUNNING t0+4;
//     endof_frame at t0+8 and t0+13; endof_burst at t0+13; ARMED at t0+14.
//  2. delay=0, len=1, burst=0, sync -> RUNNING next cycle; endof_frame every cycle indefinitely; endof_burst never.
//  3. Running with len=4, drop tdd_enable mid-frame -> next cycle IDLE, counter=0; sync same cycle as enable low is ignored.
//  4. Change len from 4 to 8 while RUNNING -> frames stay 4 until re-armed; after burst end plus new sync, frames are 8.
//  5. Sync while RUNNING at counter=2 -> no effect (macro off);
//     macro on -> WAITING with counter=0 and burst counter cleared.
//  6. resetn low for 1 cycle at counter=3 of len=5 -> IDLE, counter=0, no endof_frame; resumes ARMED after release.

Source files
------------

// File: rtl/axi_tdd_ng_pkg.sv
// Shared types for the TDD frame timing core.
package axi_tdd_ng_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    WAITING = 2'd2,
    RUNNING = 2'd3
  } state_t;

endpackage

// File: rtl/axi_tdd_ng_counter.sv
// TDD frame timing core: arm, wait for sync, count startup delay, then run a burst of frames.
// Optional macro AXI_TDD_NG_SYNC_RESTART_EN lets a sync during WAITING/RUNNING restart the sequence.
module axi_tdd_ng_counter
  import axi_tdd_ng_pkg::*;
#(
  parameter int REGISTER_WIDTH    = 32,
  parameter int BURST_COUNT_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         tdd_enable,
  input  logic                         tdd_sync,
  input  logic [REGISTER_WIDTH-1:0]    tdd_startup_delay,
  input  logic [REGISTER_WIDTH-1:0]    tdd_frame_length,
  input  logic [BURST_COUNT_WIDTH-1:0] tdd_burst_count,
  output logic [1:0]                   tdd_cstate,
  output logic [REGISTER_WIDTH-1:0]    tdd_counter,
  output logic                         tdd_endof_frame,
  output logic                         tdd_endof_burst
);

  localparam logic [REGISTER_WIDTH-1:0]    R_ONE = REGISTER_WIDTH'(1);
  localparam logic [BURST_COUNT_WIDTH-1:0] B_ONE = BURST_COUNT_WIDTH'(1);

  state_t                         state_q, state_d;
  logic [REGISTER_WIDTH-1:0]      counter_q, counter_d;
  logic [BURST_COUNT_WIDTH-1:0]   burst_cnt_q, burst_cnt_d;
  logic [REGISTER_WIDTH-1:0]      delay_q, delay_d;
  logic [REGISTER_WIDTH-1:0]      len_q, len_d;
  logic [BURST_COUNT_WIDTH-1:0]   burst_q, burst_d;

  logic frame_end;
  logic burst_end;
  logic sync_restart;

  // Frame length 0 wraps to 2^W because len_q - 1 is all ones.
  assign frame_end = (state_q == RUNNING) && (counter_q == len_q - R_ONE);
  assign burst_end = frame_end && (burst_q != '0) && (burst_cnt_q == burst_q - B_ONE);

`ifdef AXI_TDD_NG_SYNC_RESTART_EN
  assign sync_restart = tdd_enable && tdd_sync &&
                        ((state_q == WAITING) || (state_q == RUNNING));
`else
  assign sync_restart = 1'b0;
`endif

  assign tdd_endof_frame = frame_end && !sync_restart;
  assign tdd_endof_burst = burst_end && !sync_restart;
  assign tdd_cstate      = state_q;
  assign tdd_counter     = counter_q;

  always_comb begin
    // NOTE: every _d gets a hold default first so no path through the case infers a latch.
    state_d     = state_q;
    counter_d   = counter_q;
    burst_cnt_d = burst_cnt_q;
    delay_d     = delay_q;
    len_d       = len_q;
    burst_d     = burst_q;

    unique case (state_q)
      IDLE: state_d = ARMED;
      ARMED: begin
        if (tdd_sync) begin
          delay_d     = tdd_startup_delay;
          len_d       = tdd_frame_length;
          burst_d     = tdd_burst_count;
          counter_d   = '0;
          burst_cnt_d = '0;
          state_d     = (tdd_startup_delay != '0) ? WAITING : RUNNING;
        end
      end
      WAITING: begin
        if (counter_q == delay_q - R_ONE) begin
          counter_d = '0;
          state_d   = RUNNING;
        end else begin
          counter_d = counter_q + R_ONE;
        end
      end
      RUNNING: begin
        if (frame_end) begin
          counter_d = '0;
          if (burst_end) begin
            burst_cnt_d = '0;
            state_d     = ARMED;
          end else if (burst_q != '0) begin
            burst_cnt_d = burst_cnt_q + B_ONE;
          end
        end else begin
          counter_d = counter_q + R_ONE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (sync_restart) begin
      delay_d     = tdd_startup_delay;
      len_d       = tdd_frame_length;
      burst_d     = tdd_burst_count;
      counter_d   = '0;
      burst_cnt_d = '0;
      state_d     = (tdd_startup_delay != '0) ? WAITING : RUNNING;
    end

    // Disable dominates everything, including a sync in the same cycle.
    if (!tdd_enable) begin
      state_d     = IDLE;
      counter_d   = '0;
      burst_cnt_d = '0;
    end
  end

  // NOTE: reset is sampled on the clock edge only; it is not in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      // NOTE: non-blocking so every flop updates from the same pre-edge values.
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      counter_q   <= '0;
      burst_cnt_q <= '0;
      delay_q     <= '0;
      len_q       <= '0;
      burst_q     <= '0;
    end else begin
      counter_q   <= counter_d;
      burst_cnt_q <= burst_cnt_d;
      delay_q     <= delay_d;
      len_q       <= len_d;
      burst_q     <= burst_d;
    end
  end

endmodule

// File: tb/tb_axi_tdd_ng_counter.sv
// Randomized bench for axi_tdd_ng_counter against a time-since-sync reference model.
module tb_axi_tdd_ng_counter;

  localparam int RW = 6;
  localparam int BW = 4;
  localparam int LEN_WRAP = 1 << RW;

  logic          clk = 1'b0;
  logic          resetn;
  logic          tdd_enable;
  logic          tdd_sync;
  logic [RW-1:0] tdd_startup_delay;
  logic [RW-1:0] tdd_frame_length;
  logic [BW-1:0] tdd_burst_count;
  logic [1:0]    tdd_cstate;
  logic [RW-1:0] tdd_counter;
  logic          tdd_endof_frame;
  logic          tdd_endof_burst;

  axi_tdd_ng_counter #(
    .REGISTER_WIDTH   (RW),
    .BURST_COUNT_WIDTH(BW)
  ) dut (
    .clk              (clk),
    .resetn           (resetn),
    .tdd_enable       (tdd_enable),
    .tdd_sync         (tdd_sync),
    .tdd_startup_delay(tdd_startup_delay),
    .tdd_frame_length (tdd_frame_length),
    .tdd_burst_count  (tdd_burst_count),
    .tdd_cstate       (tdd_cstate),
    .tdd_counter      (tdd_counter),
    .tdd_endof_frame  (tdd_endof_frame),
    .tdd_endof_burst  (tdd_endof_burst)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Model: phase 0 idle, 1 armed, 2 active; e counts cycles elapsed since the latching sync.
  int     m_phase = 0;
  longint m_e     = 0;
  longint m_delay = 0;
  longint m_len   = 1;
  longint m_burst = 0;

  bit restart_on;
  initial begin
`ifdef AXI_TDD_NG_SYNC_RESTART_EN
    restart_on = 1'b1;
`else
    restart_on = 1'b0;
`endif
  end

  task automatic latch(input int d, input int l, input int b);
    m_delay = d;
    m_len   = (l == 0) ? LEN_WRAP : l;
    m_burst = b;
    m_e     = 1;
    m_phase = 2;
  endtask

  task automatic step(input bit rst_n, input bit en, input bit sy,
                      input int d, input int l, input int b);
    longint r;
    int     exp_state;
    longint exp_cnt;
    bit     exp_eof, exp_eob, restart;
    @(negedge clk);
    resetn            = rst_n;
    tdd_enable        = en;
    tdd_sync          = sy;
    tdd_startup_delay = RW'(d);
    tdd_frame_length  = RW'(l);
    tdd_burst_count   = BW'(b);
    #1;
    restart   = restart_on && (m_phase == 2) && sy && en;
    exp_state = 0; exp_cnt = 0; exp_eof = 0; exp_eob = 0;
    if (m_phase == 1) begin
      exp_state = 1;
    end else if (m_phase == 2) begin
      if (m_e <= m_delay) begin
        exp_state = 2;
        exp_cnt   = m_e - 1;
      end else begin
        r         = m_e - m_delay - 1;
        exp_state = 3;
        exp_cnt   = r % m_len;
        exp_eof   = (exp_cnt == m_len - 1) && !restart;
        exp_eob   = exp_eof && (m_burst != 0) && (r / m_len == m_burst - 1);
      end
    end
    check("cstate",      64'(tdd_cstate),      64'(exp_state));
    check("counter",     64'(tdd_counter),     64'(exp_cnt));
    check("endof_frame", 64'(tdd_endof_frame), 64'(exp_eof));
    check("endof_burst", 64'(tdd_endof_burst), 64'(exp_eob));
    @(posedge clk);
    if (!rst_n || !en) begin
      m_phase = 0;
      m_e     = 0;
    end else if (m_phase == 0) begin
      m_phase = 1;
    end else if (m_phase == 1) begin
      if (sy) latch(d, l, b);
    end else if (restart) begin
      latch(d, l, b);
    end else begin
      m_e++;
      if (m_burst != 0 && m_e == m_delay + m_burst * m_len + 1) m_phase = 1;
    end
  endtask

  task automatic run(input int n, input int d, input int l, input int b);
    for (int i = 0; i < n; i++) step(1, 1, 0, d, l, b);
  endtask

  initial begin
    resetn = 0; tdd_enable = 0; tdd_sync = 0;
    tdd_startup_delay = '0; tdd_frame_length = '0; tdd_burst_count = '0;
    repeat (2) @(posedge clk);

    // Reset state, then the basic delay/frame/burst sequence.
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 1, 3, 5, 2);          // IDLE->ARMED; this sync is lost
    step(1, 1, 1, 3, 5, 2);
    run(16, 3, 5, 2);

    // Zero delay, single-cycle frames, infinite burst.
    step(1, 1, 1, 0, 1, 0);
    run(20, 0, 1, 0);

    // Disable mid-frame with a simultaneous sync.
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 4, 0);
    step(1, 1, 1, 0, 4, 0);
    run(6, 0, 4, 0);
    step(1, 0, 1, 0, 4, 0);
    step(1, 1, 0, 0, 4, 0);
    step(1, 1, 0, 0, 4, 0);

    // Frame length changes while running take effect only after re-arm.
    step(1, 1, 1, 1, 4, 2);
    run(12, 1, 8, 2);
    step(1, 1, 1, 1, 8, 2);
    run(20, 1, 8, 2);

    // Sync while running at counter 2.
    step(1, 1, 1, 0, 5, 3);
    run(2, 0, 5, 3);
    step(1, 1, 1, 2, 5, 3);
    run(12, 2, 5, 3);

    // Reset pulse mid-frame.
    step(1, 1, 1, 0, 5, 1);
    run(3, 0, 5, 1);
    step(0, 1, 0, 0, 5, 1);
    run(3, 0, 5, 1);

    // Frame length 0 wraps to 2^RW cycles.
    step(1, 1, 1, 2, 0, 1);
    run(2 + LEN_WRAP + 3, 2, 0, 1);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(199, 0) != 0,
           $urandom_range(39, 0) != 0,
           $urandom_range(5, 0) == 0,
           $urandom_range(4, 0),
           ($urandom_range(15, 0) == 0) ? 0 : $urandom_range(6, 1),
           $urandom_range(3, 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
